digi_ota_array: RTL and testbench

Multi-channel clocked successor to the combinational digital OTA cell. Each channel compares a digital input pair, drives its output only while the pair disagrees, and integrates the differential drive into a saturating up/down accumulator that models the OTA's load capacitor. A threshold comparator (optional hysteresis) converts the accumulator level to a logic output. The block sits between the analog-pin input pairs and the tile's output/enable pins.

---
 rtl/digi_ota_array_if.sv | 28 ++
 rtl/digi_ota_array.sv | 108 ++++++++++
 tb/tb_digi_ota_array.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digi_ota_array_if.sv
// Bus bundle for digi_ota_array: global enable, per-channel input pairs,
// and the per-channel registered outputs.
//
// Signalling semantics: there is no valid/ready handshake on this bus.
// The inputs are level signals. vip/vin may change at any time with no
// relation to clk, and they are synchronized inside the slave. ena is
// sampled directly on each rising edge. out/oe/sat are registered levels
// that the slave updates only on rising edges or on reset.
interface digi_ota_array_if #(
  parameter int CHANNELS = 2
);
  logic                ena;
  logic [CHANNELS-1:0] vip;
  logic [CHANNELS-1:0] vin;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] oe;
  logic [CHANNELS-1:0] sat;

  modport master (
    output ena, vip, vin,
    input  out, oe, sat
  );

  modport slave (
    input  ena, vip, vin,
    output out, oe, sat
  );
endinterface

// File: rtl/digi_ota_array.sv
// digi_ota_array: multi-channel clocked digital OTA.
// Each channel synchronizes its vip/vin pair and integrates the
// differential drive into a saturating accumulator. The accumulator stands
// in for the load capacitor. A comparator turns the accumulator level into
// a logic output.
// Optional feature macro: DIGI_OTA_HYST_EN selects a hysteresis comparator
// with thresholds at 1/4 and 3/4 of full scale. When it is undefined, the
// comparator uses a single threshold at mid-scale.
module digi_ota_array #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 4,
  parameter int STEP     = 1
) (
  input logic             clk,
  input logic             rst_n,
  digi_ota_array_if.slave bus
);

  // The extended-width copies let the sums be formed one bit wider than
  // the accumulator, so overflow and borrow are visible and never wrap.
  localparam logic [ACC_W:0]   MAX_X = (ACC_W+1)'((2**ACC_W) - 1);
  localparam logic [ACC_W:0]   STEP_X = (ACC_W+1)'(STEP);
  localparam logic [ACC_W-1:0] MAX_V = ACC_W'((2**ACC_W) - 1);
  localparam logic [ACC_W-1:0] RST_V = ACC_W'((2**(ACC_W-1)) - 1);
`ifdef DIGI_OTA_HYST_EN
  localparam logic [ACC_W-1:0] LO_V  = ACC_W'(2**(ACC_W-2));
  localparam logic [ACC_W-1:0] HI_V  = ACC_W'(3 * (2**(ACC_W-2)));
`else
  localparam logic [ACC_W-1:0] MID_V = ACC_W'(2**(ACC_W-1));
`endif

  logic [CHANNELS-1:0]            p_s1, p_s2, n_s1, n_s2;
  logic [CHANNELS-1:0][ACC_W-1:0] acc, acc_next;
  logic [CHANNELS-1:0][ACC_W:0]   up_sum, dn_sum;
  logic [CHANNELS-1:0]            out_q, oe_q, sat_q;
  logic [CHANNELS-1:0]            out_next, oe_next, sat_next;

  assign bus.out = out_q;
  assign bus.oe  = oe_q;
  assign bus.sat = sat_q;

  // Two-flop synchronizers for the asynchronous input pairs. These run
  // even while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_s1 <= '0;
      p_s2 <= '0;
      n_s1 <= '0;
      n_s2 <= '0;
    end else begin
      p_s1 <= bus.vip;
      p_s2 <= p_s1;
      n_s1 <= bus.vin;
      n_s2 <= n_s1;
    end
  end

  // Next-state logic for each channel: saturating integration,
  // drive-enable, saturation flag and comparator.
  always_comb begin
    acc_next = acc;
    up_sum   = '0;
    dn_sum   = '0;
    oe_next  = '0;
    sat_next = '0;
    out_next = out_q;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      up_sum[ch] = {1'b0, acc[ch]} + STEP_X;
      dn_sum[ch] = {1'b0, acc[ch]} - STEP_X;
      if (bus.ena && p_s2[ch] && !n_s2[ch]) begin
        acc_next[ch] = (up_sum[ch] > MAX_X) ? MAX_V : up_sum[ch][ACC_W-1:0];
      end else if (bus.ena && !p_s2[ch] && n_s2[ch]) begin
        // A set top bit means the subtraction borrowed, so clamp to zero.
        acc_next[ch] = dn_sum[ch][ACC_W] ? '0 : dn_sum[ch][ACC_W-1:0];
      end
      oe_next[ch]  = bus.ena & (p_s2[ch] ^ n_s2[ch]);
      sat_next[ch] = (acc_next[ch] == '0) || (acc_next[ch] == MAX_V);
      if (bus.ena) begin
`ifdef DIGI_OTA_HYST_EN
        if (acc_next[ch] >= HI_V) begin
          out_next[ch] = 1'b1;
        end else if (acc_next[ch] <= LO_V) begin
          out_next[ch] = 1'b0;
        end
`else
        out_next[ch] = (acc_next[ch] >= MID_V);
`endif
      end
    end
  end

  // Accumulator and output registers. They update together, so out has
  // the same latency as acc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= {CHANNELS{RST_V}};
      out_q <= '0;
      oe_q  <= '0;
      sat_q <= '0;
    end else begin
      acc   <= acc_next;
      out_q <= out_next;
      oe_q  <= oe_next;
      sat_q <= sat_next;
    end
  end

endmodule

// File: tb/tb_digi_ota_array.sv
// Testbench for digi_ota_array. It checks the block against a behavioural
// model that applies the integration rules to plain integers.
module tb_digi_ota_array;
  localparam int CH    = 2;
  localparam int ACC_W = 4;
  localparam int STEP  = 1;
  localparam int MAX   = (1 << ACC_W) - 1;
  localparam int MID   = 1 << (ACC_W - 1);
`ifdef DIGI_OTA_HYST_EN
  localparam int LO    = 1 << (ACC_W - 2);
  localparam int HI    = 3 * (1 << (ACC_W - 2));
  localparam bit HYST  = 1'b1;
`else
  localparam bit HYST  = 1'b0;
`endif

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  digi_ota_array_if #(.CHANNELS(CH)) bus();

  digi_ota_array #(.CHANNELS(CH), .ACC_W(ACC_W), .STEP(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state. An input pair affects the accumulator on the
  // second edge after the edge that first samples it, so the model keeps
  // the last two sampled pairs in a queue.
  int              m_acc [CH];
  logic [CH-1:0]   m_out, m_oe, m_sat;
  logic [CH-1:0]   smp_p[$];
  logic [CH-1:0]   smp_n[$];

  task automatic model_reset();
    for (int ch = 0; ch < CH; ch++) m_acc[ch] = MID - 1;
    m_out = '0;
    m_oe  = '0;
    m_sat = '0;
    smp_p.delete();
    smp_n.delete();
    smp_p.push_back('0);
    smp_p.push_back('0);
    smp_n.push_back('0);
    smp_n.push_back('0);
  endtask

  task automatic model_edge();
    logic [CH-1:0] p, n;
    p = smp_p.pop_front();
    n = smp_n.pop_front();
    smp_p.push_back(bus.vip);
    smp_n.push_back(bus.vin);
    for (int ch = 0; ch < CH; ch++) begin
      if (bus.ena && p[ch] && !n[ch]) m_acc[ch] = (m_acc[ch] + STEP > MAX) ? MAX : m_acc[ch] + STEP;
      else if (bus.ena && !p[ch] && n[ch]) m_acc[ch] = (m_acc[ch] - STEP < 0) ? 0 : m_acc[ch] - STEP;
      m_oe[ch]  = bus.ena & (p[ch] ^ n[ch]);
      m_sat[ch] = (m_acc[ch] == 0) || (m_acc[ch] == MAX);
      if (bus.ena) begin
`ifdef DIGI_OTA_HYST_EN
        if (m_acc[ch] >= HI) m_out[ch] = 1'b1;
        else if (m_acc[ch] <= LO) m_out[ch] = 1'b0;
`else
        m_out[ch] = (m_acc[ch] >= MID);
`endif
      end
    end
  endtask

  // Driver tasks. Inputs change 1 time unit after the rising edge, and
  // outputs are sampled at that same point.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_pair(input int ch, input logic p, input logic n);
    bus.vip[ch] = p;
    bus.vin[ch] = n;
  endtask

  // Moves channel 0 by a known number of updates, then holds it. There is
  // one drive sample per update, followed by two edges to drain the input
  // pipeline.
  task automatic move_to(input int target);
    int steps;
    logic up;
    up    = (target > m_acc[0]);
    steps = up ? (target - m_acc[0]) / STEP : (m_acc[0] - target) / STEP;
    set_pair(0, up, !up);
    repeat (steps) tick();
    set_pair(0, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.ena = 1'b0;
    bus.vip = '0;
    bus.vin = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.out, bus.oe, bus.sat} !== '0)
      begin errors++; $display("FAIL reset_state got out=%b oe=%b sat=%b exp all 0", bus.out, bus.oe, bus.sat); end
    #3;
    rst_n = 1'b1;
    model_reset();
    bus.ena = 1'b1;
    tick();
    checks++;
    if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
      begin errors++; $display("FAIL reset_idle got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
  endtask

  task automatic test_drive_up();
    set_pair(0, 1'b1, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
        begin errors++; $display("FAIL drive_up cyc=%0d got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", i, bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
      if (i == 2) begin
        checks++;
        if (bus.oe[0] !== 1'b0) begin errors++; $display("FAIL latency_early got oe0=%b exp 0", bus.oe[0]); end
      end
      if (i == 3) begin
        checks++;
        if ({bus.oe[0], bus.out[0]} !== {1'b1, !HYST})
          begin errors++; $display("FAIL first_update got oe0=%b out0=%b exp oe0=1 out0=%b", bus.oe[0], bus.out[0], !HYST); end
      end
      if (i == 6 || i == 7) begin
        checks++;
        if (bus.out[0] !== (HYST ? (i == 7) : 1'b1))
          begin errors++; $display("FAIL threshold cyc=%0d got out0=%b exp %b", i, bus.out[0], HYST ? (i == 7) : 1'b1); end
      end
    end
    checks++;
    if (bus.sat[0] !== 1'b1) begin errors++; $display("FAIL sat_high got sat0=%b exp 1", bus.sat[0]); end
  endtask

  task automatic test_saturation_down();
    set_pair(0, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++;
      if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
        begin errors++; $display("FAIL drive_down cyc=%0d got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", i, bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
      if (i == 3) begin
        checks++;
        if (bus.sat[0] !== 1'b0) begin errors++; $display("FAIL sat_release got sat0=%b exp 0", bus.sat[0]); end
      end
    end
    checks++;
    if ({bus.sat[0], bus.out[0]} !== 2'b10)
      begin errors++; $display("FAIL sat_low got sat0=%b out0=%b exp sat0=1 out0=0", bus.sat[0], bus.out[0]); end
  endtask

  task automatic test_equal_inputs();
    set_pair(0, 1'b1, 1'b1);
    set_pair(1, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
        begin errors++; $display("FAIL equal cyc=%0d got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", i, bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
    end
    checks++;
    if ({bus.oe, bus.out[0], bus.sat[0]} !== {2'b10, 1'b0, 1'b1})
      begin errors++; $display("FAIL independence got oe=%b out0=%b sat0=%b exp oe=10 out0=0 sat0=1", bus.oe, bus.out[0], bus.sat[0]); end
    set_pair(0, 1'b0, 1'b0);
    set_pair(1, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_hysteresis();
    int targets [4] = '{12, 5, 4, 11};
    logic exp_out [4];
    exp_out = HYST ? '{1'b1, 1'b1, 1'b0, 1'b0} : '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      move_to(targets[k]);
      checks++;
      if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
        begin errors++; $display("FAIL hyst_model lvl=%0d got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", targets[k], bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
      checks++;
      if (bus.out[0] !== exp_out[k])
        begin errors++; $display("FAIL hyst_out lvl=%0d got out0=%b exp %b", targets[k], bus.out[0], exp_out[k]); end
    end
  endtask

  task automatic test_ena_gating();
    int guard;
    move_to(8);
    set_pair(0, 1'b1, 1'b0);
    guard = 0;
    while (m_acc[0] != 10 && guard < 10) begin tick(); guard++; end
    checks++;
    if (guard >= 10) begin errors++; $display("FAIL ena_setup got guard=%0d exp below 10", guard); end
    bus.ena = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
        begin errors++; $display("FAIL ena_low cyc=%0d got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", i, bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
      checks++;
      if (bus.oe[0] !== 1'b0) begin errors++; $display("FAIL ena_oe cyc=%0d got oe0=%b exp 0", i, bus.oe[0]); end
    end
    bus.ena = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
        begin errors++; $display("FAIL ena_resume cyc=%0d got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", i, bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (m_acc[0] != 13 && guard < 20) begin
      tick();
      guard++;
      checks++;
      if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
        begin errors++; $display("FAIL pre_reset cyc=%0d got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", guard, bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out, bus.oe, bus.sat} !== '0)
      begin errors++; $display("FAIL async_clear got out=%b oe=%b sat=%b exp all 0", bus.out, bus.oe, bus.sat); end
    bus.vip = '0;
    bus.vin = '0;
    #1;
    rst_n = 1'b1;
    model_reset();
    tick();
    checks++;
    if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
      begin errors++; $display("FAIL post_reset got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
    move_to(8);
    checks++;
    if (bus.out[0] !== !HYST) begin errors++; $display("FAIL post_reset_level got out0=%b exp %b", bus.out[0], !HYST); end
  endtask

  task automatic test_random();
    for (int i = 1; i <= 400; i++) begin
      bus.vip = CH'($urandom_range(0, (1 << CH) - 1));
      bus.vin = CH'($urandom_range(0, (1 << CH) - 1));
      bus.ena = ($urandom_range(0, 9) != 0);
      tick();
      checks++;
      if ({bus.out, bus.oe, bus.sat} !== {m_out, m_oe, m_sat})
        begin errors++; $display("FAIL random cyc=%0d got out=%b oe=%b sat=%b exp out=%b oe=%b sat=%b", i, bus.out, bus.oe, bus.sat, m_out, m_oe, m_sat); end
    end
  endtask

  initial begin
    test_reset();
    test_drive_up();
    test_saturation_down();
    test_equal_inputs();
    test_hysteresis();
    test_ena_gating();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the bench must always terminate.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
